// File: rtl/systolic_pkg.sv
// Shared definitions for the 2x2 systolic array and its input-skew feeder.
// Keeps state encoding, array size and default operand width in one place.
package systolic_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int ARRAY_N        = 2;
    localparam int FEED_BEATS     = 2 * ARRAY_N - 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_FEED  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/systolic_skew_mux.sv
// Beat-index to skewed row/column stream selector; purely combinational.
// Streams are zero when not enabled or the beat index is out of range.
module systolic_skew_mux
    import systolic_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              en,
    input  logic [1:0]        beat,
    input  logic [DATA_W-1:0] a_m00,
    input  logic [DATA_W-1:0] a_m01,
    input  logic [DATA_W-1:0] a_m10,
    input  logic [DATA_W-1:0] a_m11,
    input  logic [DATA_W-1:0] b_m00,
    input  logic [DATA_W-1:0] b_m01,
    input  logic [DATA_W-1:0] b_m10,
    input  logic [DATA_W-1:0] b_m11,
    output logic [DATA_W-1:0] a_row0,
    output logic [DATA_W-1:0] a_row1,
    output logic [DATA_W-1:0] b_col0,
    output logic [DATA_W-1:0] b_col1
);

    // Row i of A is delayed by i beats, column j of B by j beats.
    always_comb begin
        a_row0 = '0;
        a_row1 = '0;
        b_col0 = '0;
        b_col1 = '0;
        if (en) begin
            case (beat)
                2'd0: begin
                    a_row0 = a_m00;
                    b_col0 = b_m00;
                end
                2'd1: begin
                    a_row0 = a_m01;
                    a_row1 = a_m10;
                    b_col0 = b_m10;
                    b_col1 = b_m01;
                end
                2'd2: begin
                    a_row1 = a_m11;
                    b_col1 = b_m11;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/systolic_feeder_2x2.sv
// Captures A/B on start, emits clear strobe, 3 skewed feed beats, DRAIN_CYCLES zero beats, then done.
// Latency start->done is 5+DRAIN_CYCLES cycles; no backpressure, start outside IDLE is dropped.
module systolic_feeder_2x2
    import systolic_pkg::*;
#(
    parameter int DATA_W       = DEFAULT_DATA_W,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] a_m00,
    input  logic [DATA_W-1:0] a_m01,
    input  logic [DATA_W-1:0] a_m10,
    input  logic [DATA_W-1:0] a_m11,
    input  logic [DATA_W-1:0] b_m00,
    input  logic [DATA_W-1:0] b_m01,
    input  logic [DATA_W-1:0] b_m10,
    input  logic [DATA_W-1:0] b_m11,
    output logic [DATA_W-1:0] a_row0,
    output logic [DATA_W-1:0] a_row1,
    output logic [DATA_W-1:0] b_col0,
    output logic [DATA_W-1:0] b_col1,
    output logic              acc_clr,
    output logic              feed_valid,
    output logic              busy,
    output logic              done
);

    localparam int DRAIN_W = $clog2(DRAIN_CYCLES) + 1;

    state_t             state, state_nxt;
    logic [1:0]         feed_cnt, feed_cnt_nxt;
    logic [DRAIN_W-1:0] drain_cnt, drain_cnt_nxt;

    logic [DATA_W-1:0] a00_q, a01_q, a10_q, a11_q;
    logic [DATA_W-1:0] b00_q, b01_q, b10_q, b11_q;
    logic [DATA_W-1:0] a_row0_nxt, a_row1_nxt, b_col0_nxt, b_col1_nxt;

    always_comb begin
        state_nxt     = state;
        feed_cnt_nxt  = feed_cnt;
        drain_cnt_nxt = drain_cnt;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_nxt    = ST_FEED;
                feed_cnt_nxt = '0;
            end
            ST_FEED: begin
                if (feed_cnt == 2'(FEED_BEATS - 1)) begin
                    state_nxt     = ST_DRAIN;
                    feed_cnt_nxt  = '0;
                    drain_cnt_nxt = '0;
                end else begin
                    feed_cnt_nxt = feed_cnt + 2'd1;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt == DRAIN_W'(DRAIN_CYCLES - 1)) begin
                    state_nxt     = ST_DONE;
                    drain_cnt_nxt = '0;
                end else begin
                    drain_cnt_nxt = drain_cnt + 1'b1;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt     = ST_IDLE;
                feed_cnt_nxt  = '0;
                drain_cnt_nxt = '0;
            end
        endcase
    end

    // Streams are selected from the next beat so every output leaves a register.
    systolic_skew_mux #(
        .DATA_W (DATA_W)
    ) u_skew_mux (
        .en     (state_nxt == ST_FEED),
        .beat   (feed_cnt_nxt),
        .a_m00  (a00_q),
        .a_m01  (a01_q),
        .a_m10  (a10_q),
        .a_m11  (a11_q),
        .b_m00  (b00_q),
        .b_m01  (b01_q),
        .b_m10  (b10_q),
        .b_m11  (b11_q),
        .a_row0 (a_row0_nxt),
        .a_row1 (a_row1_nxt),
        .b_col0 (b_col0_nxt),
        .b_col1 (b_col1_nxt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            feed_cnt   <= '0;
            drain_cnt  <= '0;
            a00_q      <= '0;
            a01_q      <= '0;
            a10_q      <= '0;
            a11_q      <= '0;
            b00_q      <= '0;
            b01_q      <= '0;
            b10_q      <= '0;
            b11_q      <= '0;
            a_row0     <= '0;
            a_row1     <= '0;
            b_col0     <= '0;
            b_col1     <= '0;
            acc_clr    <= 1'b0;
            feed_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            feed_cnt   <= feed_cnt_nxt;
            drain_cnt  <= drain_cnt_nxt;
            // Operands are only sampled on the accepting edge, isolating later input churn.
            if (state == ST_IDLE && start) begin
                a00_q <= a_m00;
                a01_q <= a_m01;
                a10_q <= a_m10;
                a11_q <= a_m11;
                b00_q <= b_m00;
                b01_q <= b_m01;
                b10_q <= b_m10;
                b11_q <= b_m11;
            end
            a_row0     <= a_row0_nxt;
            a_row1     <= a_row1_nxt;
            b_col0     <= b_col0_nxt;
            b_col1     <= b_col1_nxt;
            acc_clr    <= (state_nxt == ST_LOAD);
            feed_valid <= (state_nxt == ST_FEED);
            busy       <= (state_nxt == ST_LOAD) || (state_nxt == ST_FEED) ||
                          (state_nxt == ST_DRAIN);
            done       <= (state_nxt == ST_DONE);
        end
    end

endmodule

// File: tb/tb_systolic_feeder_2x2.sv
// Directed bench for systolic_feeder_2x2: expected per-cycle output vectors are
// queued when a start will be accepted and popped/compared on each falling edge.
module tb_systolic_feeder_2x2;

    localparam int DW = 32;
    localparam int DR = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] a00, a01, a10, a11, b00, b01, b10, b11;
    logic [DW-1:0] a_row0, a_row1, b_col0, b_col1;
    logic          acc_clr, feed_valid, busy, done;

    typedef struct packed {
        logic          acc_clr;
        logic          feed_valid;
        logic          busy;
        logic          done;
        logic [DW-1:0] a0;
        logic [DW-1:0] a1;
        logic [DW-1:0] b0;
        logic [DW-1:0] b1;
    } vec_t;

    vec_t  q[$];
    int    vectors     = 0;
    int    miscompares = 0;
    int    exp_done    = 0;
    int    obs_done    = 0;
    bit    mdl_idle    = 1'b1;
    string phase       = "init";

    systolic_feeder_2x2 #(
        .DATA_W       (DW),
        .DRAIN_CYCLES (DR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a_m00      (a00),
        .a_m01      (a01),
        .a_m10      (a10),
        .a_m11      (a11),
        .b_m00      (b00),
        .b_m01      (b01),
        .b_m10      (b10),
        .b_m11      (b11),
        .a_row0     (a_row0),
        .a_row1     (a_row1),
        .b_col0     (b_col0),
        .b_col1     (b_col1),
        .acc_clr    (acc_clr),
        .feed_valid (feed_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic set_ops(input int va00, va01, va10, va11, vb00, vb01, vb10, vb11);
        a00 = DW'(va00); a01 = DW'(va01); a10 = DW'(va10); a11 = DW'(va11);
        b00 = DW'(vb00); b01 = DW'(vb01); b10 = DW'(vb10); b11 = DW'(vb11);
    endtask

    // Expected beats: clear, skewed feed of A rows / B columns, zero drain, done.
    task automatic push_product();
        vec_t v;
        v = '0; v.acc_clr = 1'b1; v.busy = 1'b1;
        q.push_back(v);
        v = '0; v.feed_valid = 1'b1; v.busy = 1'b1;
        v.a0 = a00; v.b0 = b00;
        q.push_back(v);
        v.a0 = a01; v.a1 = a10; v.b0 = b10; v.b1 = b01;
        q.push_back(v);
        v.a0 = '0; v.a1 = a11; v.b0 = '0; v.b1 = b11;
        q.push_back(v);
        v = '0; v.busy = 1'b1;
        repeat (DR) q.push_back(v);
        v = '0; v.done = 1'b1;
        q.push_back(v);
        exp_done++;
    endtask

    task automatic compare(input vec_t e);
        vec_t o;
        o = {acc_clr, feed_valid, busy, done, a_row0, a_row1, b_col0, b_col1};
        vectors++;
        if (o.done === 1'b1) obs_done++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s t=%0t observed=%h expected=%h", phase, $time, o, e);
        end
    endtask

    task automatic check();
        vec_t e;
        e = '0;
        if (q.size() > 0) e = q.pop_front();
        compare(e);
        mdl_idle = (q.size() == 0) && !e.done;
    endtask

    // Drive start for the next rising edge, then check the cycle it produces.
    task automatic step(input logic s);
        start = s;
        if (s && rst && mdl_idle) push_product();
        @(negedge clk);
        check();
    endtask

    initial begin
        vec_t zero;
        zero = '0;
        rst = 1'b0;
        start = 1'b1;
        set_ops(0, 0, 0, 0, 0, 0, 0, 0);

        phase = "reset";
        step(1'b1);
        step(1'b1);
        rst = 1'b1;
        phase = "idle";
        repeat (5) step(1'b0);

        // Basic product; inputs flip to 9s mid-feed and must not leak through.
        phase = "basic";
        set_ops(1, 2, 3, 4, 5, 6, 7, 8);
        step(1'b1);
        step(1'b0);
        set_ops(9, 9, 9, 9, 9, 9, 9, 9);
        phase = "capture_hold";
        repeat (6) step(1'b0);
        repeat (2) step(1'b0);

        // Starts during FEED and during DONE are dropped.
        phase = "ignore_start";
        set_ops(10, 11, 12, 13, 14, 15, 16, 17);
        step(1'b1);
        step(1'b0);
        step(1'b1);
        repeat (5) step(1'b0);
        step(1'b1);
        repeat (3) step(1'b0);

        // start held high: back-to-back identity x 2I products.
        phase = "back_to_back";
        set_ops(1, 0, 0, 1, 2, 0, 0, 2);
        repeat (17) step(1'b1);
        repeat (3) step(1'b0);

        // Abort during beat k=1, then a fresh product.
        phase = "abort";
        set_ops(21, 22, 23, 24, 25, 26, 27, 28);
        step(1'b1);
        step(1'b0);
        step(1'b0);
        rst = 1'b0;
        #1;
        compare(zero);
        q.delete();
        exp_done--;
        mdl_idle = 1'b1;
        repeat (2) step(1'b0);
        rst = 1'b1;
        phase = "after_abort";
        step(1'b0);
        set_ops(31, 32, 33, 34, 35, 36, 37, 38);
        step(1'b1);
        repeat (9) step(1'b0);

        phase = "done_count";
        vectors++;
        assert (obs_done === exp_done) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", phase, obs_done, exp_done);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/systolic_feeder_2x2.md
Name: systolic_feeder_2x2

Overview:
Upstream input-skew stage for systolic_matrix_mul_2x2. It captures full 2x2 operand matrices A and B on a start handshake and drives the diagonally skewed row and column streams into the array's a00/a01/b00/b01 inputs. It pads with zero beats while the array drains, then pulses done. It also issues a one-cycle accumulator-clear strobe ahead of each product, so back-to-back products need no array reset.

Parameters:
DATA_W, 32, operand and stream width; must match the array port width
DRAIN_CYCLES, 3, zero-beat cycles after the last feed beat before done (legal range >=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset (asserted when 0)
start  in  1  request a new product; sampled only in IDLE
a_m00, a_m01, a_m10, a_m11  in  DATA_W each  matrix A elements (row, col)
b_m00, b_m01, b_m10, b_m11  in  DATA_W each  matrix B elements (row, col)
a_row0  out  DATA_W  row-0 A stream, to array a00
a_row1  out  DATA_W  row-1 A stream, to array a01
b_col0  out  DATA_W  col-0 B stream, to array b00
b_col1  out  DATA_W  col-1 B stream, to array b01
acc_clr  out  1  one-cycle clear strobe to the array accumulators
feed_valid  out  1  high on cycles carrying feed beats
busy  out  1  high from the cycle after start acceptance until done
done  out  1  one-cycle pulse; array results are final

Behaviour:
- All outputs are registered. On rst=0, asynchronously: state=IDLE, all streams=0, acc_clr=0, feed_valid=0, busy=0, done=0, beat counter=0.
- States: IDLE -> LOAD -> FEED -> DRAIN -> DONE -> IDLE.
- IDLE: streams=0. When start=1 at edge N, all 8 operands latch into internal registers and the state moves to LOAD. Inputs may then change freely.
- LOAD (cycle N+1): acc_clr=1, busy=1, streams=0.
- FEED (cycles N+2..N+4), with beat counter k = 0, 1, 2 and feed_valid=1:
  k=0: a_row0=A00, a_row1=0, b_col0=B00, b_col1=0
  k=1: a_row0=A01, a_row1=A10, b_col0=B10, b_col1=B01
  k=2: a_row0=0, a_row1=A11, b_col0=0, b_col1=B11
- DRAIN (cycles N+5..N+4+DRAIN_CYCLES): streams=0, feed_valid=0, busy=1. The counter runs 0..DRAIN_CYCLES-1.
- DONE (cycle N+5+DRAIN_CYCLES): done=1, busy=0, streams=0, then IDLE.
- start outside IDLE is ignored and not queued. This includes start high in the DONE cycle.
- start held high continuously gives back-to-back products: a new acceptance at the edge ending the IDLE cycle after each DONE.
- Operand values pass through unmodified (no arithmetic, no sign handling). The counter is 2 bits for FEED; the DRAIN counter width is clog2(DRAIN_CYCLES)+1. There is no wrap beyond the terminal count.
- rst asserted mid-operation aborts the product: no done pulse, and the captured operands are discarded (cleared to 0).
- X on operand inputs outside the capture edge must not propagate to the outputs.

Decomposition:
- Shared package systolic_pkg holds:
  - state encoding constants ST_IDLE, ST_LOAD, ST_FEED, ST_DRAIN, ST_DONE
  - FEED_BEATS=2*N-1 for N=2
  - default DATA_W, so the array and feeder agree
- One natural sub-module: systolic_skew_mux, a combinational beat-index to four-stream selector. It is reused for larger N. The FSM and registers stay in the top.

Test Plan:
1. Reset with rst=0, start=1 -> all outputs 0. Release rst, hold start=0 for 5 cycles -> busy=0, streams stay 0.
2. A=[[1,2],[3,4]], B=[[5,6],[7,8]], start pulse at edge N -> acc_clr=1 at N+1. Beats (a_row0, a_row1, b_col0, b_col1) are (1,0,5,0), (2,3,7,6), (0,4,0,8) at N+2..N+4. Zeros for 3 cycles, done at N+8. With the array connected: c00=19, c01=22, c10=43, c11=50.
3. Change A/B inputs to all 9s during FEED -> streams still carry the captured values from scenario 2.
4. Pulse start during FEED and during DONE -> ignored; exactly one done pulse per accepted start.
5. Hold start high with A=identity, B=[[2,0],[0,2]] -> two consecutive products. The second acc_clr is one idle cycle after the first done. Array results after the second done: c00=2, c01=0, c10=0, c11=2.
6. Pull rst low during the k=1 beat -> outputs 0 immediately, with no done. After release, a new start works normally with fresh operands.
